inst_fetch_bridge: RTL
======================

Name: inst_fetch_bridge

Overview:
- Responder side of the PC register's fetch path: takes the current PC and a fetch request, runs one transaction on the SRAM-like instruction bus, and returns the instruction to decode.
- Generates the stall that drives the PC enable low.
- Discards in-flight responses when an exception or redirect flush occurs, so a stale instruction never reaches decode.

Parameters:
- ADDR_W, 32, width of the fetch address and bus address.
- DATA_W, 32, width of the instruction word.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- fetch_valid  in  1  PC holds an address to fetch.
- fetch_addr  in  ADDR_W  PC value.
- flush  in  1  exception/redirect, same cycle as the PC clear.
- pipe_stall  in  1  decode cannot accept an instruction this cycle.
- fetch_stall  out  1  hold PC; PC enable = ~fetch_stall.
- inst  out  DATA_W  fetched instruction.
- inst_valid  out  1  inst and inst_adel are valid.
- inst_adel  out  1  address-error-on-fetch flag; inst = 0 when set.
- inst_req  out  1  bus request.
- inst_wr  out  1  constant 0.
- inst_size  out  2  constant 2'b10 (word).
- inst_addr  out  ADDR_W  bus address.
- inst_addr_ok  in  1  bus accepted the address.
- inst_data_ok  in  1  bus read data valid.
- inst_rdata  in  DATA_W  bus read data.

Behaviour:
- Reset (rst=0, async):
  - state = IDLE; kill flag = 0.
  - inst_req = 0, inst_addr = 0, inst = 0, inst_valid = 0, inst_adel = 0.
  - fetch_stall forced to 0 while rst=0.
- States: IDLE, REQ, WAIT, DONE, DISCARD. All outputs except fetch_stall are registered or state-decoded.
- IDLE:
  - On fetch_valid=1 & flush=0 & fetch_addr[1:0]!=0: go to DONE with inst = 0, inst_adel = 1. No bus request is issued.
  - On fetch_valid=1 & flush=0 & aligned address: latch fetch_addr into inst_addr, go to REQ.
  - Otherwise remain in IDLE.
- REQ:
  - inst_req = 1; inst_addr stays stable until the handshake. The request is never withdrawn before inst_addr_ok.
  - flush=1 sets the kill flag.
  - On inst_addr_ok: go to DISCARD if (kill | flush), else go to WAIT. The kill flag is cleared on leaving REQ.
- WAIT:
  - inst_req = 0.
  - inst_data_ok & ~flush: capture inst_rdata into inst, inst_adel = 0, go to DONE.
  - inst_data_ok & flush: drop the data, go to IDLE.
  - flush & ~inst_data_ok: go to DISCARD.
- DISCARD: wait for inst_data_ok, drop the data, go to IDLE. flush is ignored here.
- DONE:
  - inst_valid = 1; inst and inst_adel are held.
  - flush: go to IDLE, inst_valid drops next cycle.
  - ~pipe_stall: go to IDLE (handoff complete).
  - pipe_stall: hold in DONE.
- fetch_stall = fetch_valid & ~(state==DONE & ~pipe_stall). The PC advances only in the handoff cycle; the PC's clear has priority on flush.
- Latency and throughput:
  - fetch_valid in IDLE at cycle 0, addr_ok at cycle 1, data_ok at cycle 2 gives inst_valid at cycle 3.
  - Best case one instruction per 4 cycles. Bus wait states add cycles 1:1.
- At most one outstanding bus transaction.
- Every accepted address receives exactly one data_ok consumption, even across flush.
- Reset mid-transaction: the bridge returns to IDLE. The bus is reset by the same rst.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt (32) and perf_stall_cnt (32), both reset to 0.
  - perf_fetch_cnt increments on each handoff cycle (DONE & ~pipe_stall & ~flush).
  - perf_stall_cnt increments on each cycle fetch_stall = 1.
  - Both wrap modulo 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, fetch_addr=0xBFC00000, fetch_valid=1, bus addr_ok/data_ok zero-wait, rdata=0x3C1D8000 -> inst_req at cycle 1 with inst_addr=0xBFC00000, inst_valid=1 with inst=0x3C1D8000 at cycle 3, fetch_stall=0 only at cycle 3.
- Bus stalls: addr_ok delayed 2 cycles, data_ok delayed 3 cycles -> inst_req and inst_addr held stable throughout, inst_valid at cycle 3+5=8, fetch_stall=1 in cycles 0-7.
- flush in WAIT before data_ok (rdata=0xDEADBEEF) -> DISCARD, the data_ok response is dropped, inst_valid never asserts for it. The next fetch of 0xBFC00380 returns its own data.
- flush in REQ while addr_ok is held low 2 more cycles -> inst_req stays 1 until addr_ok, then DISCARD, response dropped.
- fetch_addr=0xBFC00002 -> no inst_req, inst_valid=1 with inst_adel=1 and inst=0 at cycle 1.
- Returned instruction with pipe_stall=1 for 4 cycles -> inst_valid and inst held, fetch_stall=1; handoff in the first cycle pipe_stall=0.

Source files
------------

// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: PC-side fetch responder on an SRAM-like instruction bus.
// One bus transaction at a time; flushes turn in-flight responses into
// discards so a stale instruction never reaches decode.
// Optional build macro IFETCH_PERF_CNT_EN adds handoff/stall counters.
module inst_fetch_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              flush,
  input  logic              pipe_stall,
  output logic              fetch_stall,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              inst_adel,
  output logic              inst_req,
  output logic              inst_wr,
  output logic [1:0]        inst_size,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DISCARD} state_t;

  state_t state, nxt;
  logic   kill, kill_nxt;
  logic   lat_addr, cap_data, set_adel;

  // next-state and datapath strobes
  always_comb begin
    nxt      = state;
    kill_nxt = kill;
    lat_addr = 1'b0;
    cap_data = 1'b0;
    set_adel = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_valid && !flush) begin
          if (fetch_addr[1:0] != 2'b00) begin
            nxt      = DONE;
            set_adel = 1'b1;
          end else begin
            nxt      = REQ;
            lat_addr = 1'b1;
          end
        end
      end
      REQ: begin
        // request stays up until accepted; a flush only marks it for discard
        if (inst_addr_ok) begin
          nxt      = (kill || flush) ? DISCARD : WAIT;
          kill_nxt = 1'b0;
        end else if (flush) begin
          kill_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (inst_data_ok) begin
          nxt      = flush ? IDLE : DONE;
          cap_data = !flush;
        end else if (flush) begin
          nxt = DISCARD;
        end
      end
      DISCARD: if (inst_data_ok) nxt = IDLE;
      DONE:    if (flush || !pipe_stall) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // state and kill flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      kill  <= 1'b0;
    end else begin
      state <= nxt;
      kill  <= kill_nxt;
    end
  end

  // bus address latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          inst_addr <= '0;
    else if (lat_addr) inst_addr <= fetch_addr;
  end

  // instruction and address-error capture, held while in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst      <= '0;
      inst_adel <= 1'b0;
    end else if (cap_data) begin
      inst      <= inst_rdata;
      inst_adel <= 1'b0;
    end else if (set_adel) begin
      inst      <= '0;
      inst_adel <= 1'b1;
    end
  end

  assign inst_req    = (state == REQ);
  assign inst_valid  = (state == DONE);
  assign inst_wr     = 1'b0;
  assign inst_size   = 2'b10;
  // PC may only advance on the handoff cycle; held at 0 during reset
  assign fetch_stall = rst && fetch_valid && !(state == DONE && !pipe_stall);

`ifdef IFETCH_PERF_CNT_EN
  logic handoff;
  assign handoff = (state == DONE) && !pipe_stall && !flush;

  // handoff and stall-cycle counters, free-running with wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (handoff)     perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (fetch_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
